// File: rtl/piano_notes_pkg.sv
// Shared note table and detector constants for the C5..B5 tone generators and detector.
// Note periods are full periods in clk cycles: 2*(CLK_HZ/2/f + 1).
package piano_notes_pkg;

    localparam int unsigned NUM_NOTES      = 12;
    localparam int unsigned CLK_HZ         = 50_000_000;
    localparam int unsigned TOL_DEF        = 1024;
    localparam int unsigned MIN_PERIOD_DEF = 2000;
    localparam int unsigned PERIOD_MAX_DEF = 131071;
    localparam int unsigned CONFIRM_N      = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_MEAS,
        ST_CLASS
    } det_state_e;

    function automatic int unsigned note_hz(input int unsigned i);
        case (i)
            0:       return 523;
            1:       return 554;
            2:       return 587;
            3:       return 622;
            4:       return 659;
            5:       return 698;
            6:       return 740;
            7:       return 784;
            8:       return 831;
            9:       return 880;
            10:      return 932;
            default: return 988;
        endcase
    endfunction

    function automatic int unsigned note_period(input int unsigned clk_hz,
                                                input int unsigned i);
        return 2 * (clk_hz / 2 / note_hz(i) + 1);
    endfunction

    localparam logic [16:0] NOTE_PERIOD [NUM_NOTES] = '{
        17'(note_period(CLK_HZ, 0)),  17'(note_period(CLK_HZ, 1)),
        17'(note_period(CLK_HZ, 2)),  17'(note_period(CLK_HZ, 3)),
        17'(note_period(CLK_HZ, 4)),  17'(note_period(CLK_HZ, 5)),
        17'(note_period(CLK_HZ, 6)),  17'(note_period(CLK_HZ, 7)),
        17'(note_period(CLK_HZ, 8)),  17'(note_period(CLK_HZ, 9)),
        17'(note_period(CLK_HZ, 10)), 17'(note_period(CLK_HZ, 11))
    };

endpackage

// File: rtl/tone_period_detector_sync.sv
// Two-flop synchronizer for the tone pin followed by a rising-edge pulse.
module tone_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/tone_period_detector.sv
// Measures a square-wave tone period and classifies it as C5..B5.
// Define NOTE_DET_HYST_EN to require CONFIRM_N identical results before updating.
module tone_period_detector #(
    parameter int unsigned CLK_FREQ_HZ = piano_notes_pkg::CLK_HZ,
    parameter int unsigned TOL         = piano_notes_pkg::TOL_DEF,
    parameter int unsigned MIN_PERIOD  = piano_notes_pkg::MIN_PERIOD_DEF,
    parameter int unsigned PERIOD_MAX  = piano_notes_pkg::PERIOD_MAX_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tone_in,
    output logic [16:0] period,
    output logic [3:0]  note_idx,
    output logic        note_valid,
    output logic        note_change
);

    import piano_notes_pkg::*;

    localparam logic [16:0] CNT_MAX  = 17'(PERIOD_MAX);
    localparam logic [16:0] CNT_MIN  = 17'(MIN_PERIOD);
    localparam logic [17:0] TOL_W    = 18'(TOL);
    localparam logic [3:0]  LAST_IDX = 4'(NUM_NOTES - 1);

    logic rise;

    tone_sync_edge u_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (tone_in),
        .rise_o (rise)
    );

    logic [16:0] np [NUM_NOTES];

    for (genvar g = 0; g < NUM_NOTES; g++) begin : g_np
        assign np[g] = 17'(note_period(CLK_FREQ_HZ, g));
    end

    det_state_e  state_q, state_d;
    logic [16:0] cnt_q, cnt_d;
    logic [16:0] period_q, period_d;
    logic [3:0]  scan_q, scan_d;
    logic [3:0]  idx_q, idx_d;
    logic        valid_q, valid_d;
    logic        chg_q, chg_d;

    logic signed [17:0] diff;
    logic [17:0]        mag;
    logic               hit;
    logic               done;
    logic               timeout;
    logic               apply;

`ifdef NOTE_DET_HYST_EN
    localparam logic [3:0] CONFIRM_W = 4'(CONFIRM_N);

    logic [4:0] cand_q, cand_d, cand;
    logic [3:0] run_q, run_d, run_n;
`endif

    // 18-bit signed difference so neither side can wrap
    always_comb begin
        diff = $signed({1'b0, period_q}) - $signed({1'b0, np[scan_q]});
        mag  = diff[17] ? -diff : diff;
        hit  = mag <= TOL_W;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 17'd1;
        period_d = period_q;
        scan_d   = scan_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        done     = 1'b0;
        timeout  = 1'b0;
        apply    = 1'b0;
`ifdef NOTE_DET_HYST_EN
        cand_d   = cand_q;
        run_d    = run_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    cnt_d   = 17'd1;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED, ST_MEAS: begin
                if (rise && cnt_q >= CNT_MIN) begin
                    period_d = cnt_q;
                    cnt_d    = 17'd1;
                    scan_d   = 4'd0;
                    state_d  = ST_CLASS;
                end else if (cnt_q == CNT_MAX) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_CLASS: begin
                if (rise) begin
                    cnt_d = 17'd1;
                end
                if (hit || scan_q == LAST_IDX) begin
                    done    = 1'b1;
                    state_d = ST_MEAS;
                end else begin
                    scan_d = scan_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (timeout) begin
            valid_d = 1'b0;
        end

`ifdef NOTE_DET_HYST_EN
        cand  = hit ? {1'b1, scan_q} : 5'd0;
        run_n = (cand != cand_q) ? 4'd1 :
                (run_q >= CONFIRM_W) ? run_q : run_q + 4'd1;
        if (timeout) begin
            cand_d = 5'd0;
            run_d  = 4'd0;
        end else if (done) begin
            cand_d = cand;
            run_d  = run_n;
            apply  = run_n >= CONFIRM_W;
        end
`else
        apply = done;
`endif

        if (apply) begin
            if (hit) begin
                valid_d = 1'b1;
                idx_d   = scan_q;
            end else begin
                valid_d = 1'b0;
            end
        end

        chg_d = {valid_d, idx_d} != {valid_q, idx_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            scan_q   <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            scan_q   <= scan_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            chg_q    <= chg_d;
        end
    end

`ifdef NOTE_DET_HYST_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_q <= '0;
            run_q  <= '0;
        end else begin
            cand_q <= cand_d;
            run_q  <= run_d;
        end
    end
`endif

    assign period      = period_q;
    assign note_idx    = idx_q;
    assign note_valid  = valid_q;
    assign note_change = chg_q;

endmodule

// File: tb/tb_tone_period_detector.sv
// Bench for tone_period_detector, run on a 500 kHz note table so tones stay short.
module tb_tone_period_detector;

    localparam int CLKHZ = 500_000;
    localparam int TOLV  = 10;
    localparam int MINV  = 20;
    localparam int MAXV  = 1310;
    localparam int CONF  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tone_in = 1'b0;
    logic [16:0] period;
    logic [3:0]  note_idx;
    logic        note_valid;
    logic        note_change;

    int errors = 0;
    int checks = 0;
    int chg_cnt = 0;
    int c0;

    int fhz [12] = '{523, 554, 587, 622, 659, 698, 740, 784, 831, 880, 932, 988};
    int np  [12];

    int m, t0, mode, apply_at, pend, h_last, h_run;
    int e_period, e_idx;
    bit e_valid, e_change;
    bit h1, h2, h3;

    always #10 clk = ~clk;

    tone_period_detector #(
        .CLK_FREQ_HZ (CLKHZ),
        .TOL         (TOLV),
        .MIN_PERIOD  (MINV),
        .PERIOD_MAX  (MAXV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tone_in     (tone_in),
        .period      (period),
        .note_idx    (note_idx),
        .note_valid  (note_valid),
        .note_change (note_change)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tone_cycle(input int hi, input int lo);
        tone_in = 1'b1;
        cyc(hi);
        tone_in = 1'b0;
        cyc(lo);
    endtask

    task automatic run_tone(input int half, input int n);
        repeat (n) tone_cycle(half, half);
    endtask

    function automatic int classify(input int p);
        for (int i = 0; i < 12; i++) begin
            int d;
            d = p - np[i];
            if (d < 0) d = -d;
            if (d <= TOLV) return i;
        end
        return -1;
    endfunction

    // Event-level reference: rises seen 3 edges after the pin, timestamps
    // of the last restart, and a precomputed apply edge for each period.
    task automatic model_step();
        bit r;
        bit take;
        int el, nv, ni;
        m++;
        r  = h2 & ~h3;
        el = m - t0;
        if (el > MAXV) el = MAXV;
        nv = e_valid;
        ni = e_idx;
        case (mode)
            0: if (r) begin t0 = m; mode = 1; end
            1: begin
                if (r && el >= MINV) begin
                    e_period = el;
                    t0       = m;
                    pend     = classify(el);
                    apply_at = (pend >= 0) ? m + 1 + pend : m + 12;
                    mode     = 2;
                end else if (el >= MAXV) begin
                    nv     = 0;
                    mode   = 0;
                    h_last = -1;
                    h_run  = 0;
                end
            end
            default: begin
                if (r) t0 = m;
                if (m == apply_at) begin
                    mode = 1;
                    take = 1'b1;
`ifdef NOTE_DET_HYST_EN
                    if (pend == h_last) begin
                        if (h_run < CONF) h_run++;
                    end else begin
                        h_last = pend;
                        h_run  = 1;
                    end
                    take = (h_run >= CONF);
`endif
                    if (take) begin
                        if (pend >= 0) begin
                            nv = 1;
                            ni = pend;
                        end else begin
                            nv = 0;
                        end
                    end
                end
            end
        endcase
        e_change = (nv != int'(e_valid)) || (ni != e_idx);
        e_valid  = nv[0];
        e_idx    = ni;
        h3 = h2;
        h2 = h1;
        h1 = tone_in;
    endtask

    initial begin
        for (int i = 0; i < 12; i++) np[i] = 2 * ((CLKHZ / 2) / fhz[i] + 1);
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m = 0; t0 = 0; mode = 0; apply_at = 0; pend = -1;
                h_last = -1; h_run = 0;
                e_period = 0; e_idx = 0; e_valid = 0; e_change = 0;
                h1 = 0; h2 = 0; h3 = 0;
            end else begin
                model_step();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cycle", {period, note_idx, note_valid, note_change},
                {e_period[16:0], e_idx[3:0], e_valid, e_change});
            if (note_change) chg_cnt++;
        end
    end

    initial begin
        cyc(3);
        chk("rst_period", period, 0);
        chk("rst_idx", note_idx, 0);
        chk("rst_valid", note_valid, 0);
        chk("rst_change", note_change, 0);
        reset = 1'b0;

        c0 = chg_cnt;
        run_tone(269, 3);
        chk("asharp_period", period, 538);
        chk("asharp_idx", note_idx, 10);
        chk("asharp_valid", note_valid, 1);
        chk("asharp_pulses", chg_cnt - c0, 1);

        c0 = chg_cnt;
        run_tone(479, 3);
        chk("c5_period", period, 958);
        chk("c5_idx", note_idx, 0);
        chk("c5_valid", note_valid, 1);
        chk("c5_pulses", chg_cnt - c0, 1);

        c0 = chg_cnt;
        cyc(MAXV + 20);
        chk("tmo_valid", note_valid, 0);
        chk("tmo_idx", note_idx, 0);
        chk("tmo_pulses", chg_cnt - c0, 1);

        c0 = chg_cnt;
        run_tone(285, 3);
        chk("a5_idx", note_idx, 9);
        chk("a5_pulses", chg_cnt - c0, 1);
        c0 = chg_cnt;
        tone_in = 1'b1; cyc(15);
        tone_in = 1'b0; cyc(3);
        tone_in = 1'b1; cyc(267);
        tone_in = 1'b0; cyc(285);
        run_tone(285, 2);
        chk("glitch_period", period, 570);
        chk("glitch_idx", note_idx, 9);
        chk("glitch_valid", note_valid, 1);
        chk("glitch_pulses", chg_cnt - c0, 0);

        c0 = chg_cnt;
        run_tone(277, 3);
        chk("off_period", period, 554);
        chk("off_valid", note_valid, 0);
        chk("off_idx", note_idx, 9);
        chk("off_pulses", chg_cnt - c0, 1);

        run_tone(285, 2);
        tone_in = 1'b1;
        cyc(5);
        reset = 1'b1;
        cyc(1);
        chk("midrst_period", period, 0);
        chk("midrst_idx", note_idx, 0);
        chk("midrst_valid", note_valid, 0);
        chk("midrst_change", note_change, 0);
        reset = 1'b0;
        cyc(280);
        tone_in = 1'b0;
        cyc(285);
        run_tone(285, 3);
        chk("reacq_idx", note_idx, 9);
        chk("reacq_valid", note_valid, 1);

        for (int s = 0; s < 20; s++) begin
            int k, i, hi, lo, j, d;
            k  = $urandom_range(0, 9);
            i  = $urandom_range(0, 11);
            hi = np[i] / 2;
            lo = np[i] - hi;
            if (k <= 5) begin
                j = $urandom_range(0, 6); hi += j - 3;
                j = $urandom_range(0, 6); lo += j - 3;
            end else if (k == 6) begin
                j = $urandom_range(0, 1);
                d = TOLV + j;
                j = $urandom_range(0, 1);
                lo += (j != 0) ? d : -d;
            end else if (k == 7) begin
                hi = $urandom_range(250, 480);
                lo = $urandom_range(250, 480);
            end else if (k == 8) begin
                d = $urandom_range(1, 40);
                tone_in = 1'b1; cyc(d);
                tone_in = 1'b0; cyc(3);
                tone_in = 1'b1; cyc(hi - d - 3);
                tone_in = 1'b0; cyc(lo);
            end else begin
                j = $urandom_range(0, 2);
                if (j == 0) begin
                    d = $urandom_range(0, 30);
                    cyc(MAXV + d);
                end else begin
                    reset = 1'b1;
                    cyc(2);
                    reset = 1'b0;
                end
            end
            tone_cycle(hi, lo);
            tone_cycle(hi, lo);
        end
        cyc(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
